// File: rtl/if_stage_pkg.sv
// Shared MIPS front-end definitions: datapath widths, IF FSM state
// encodings and the NOP word. Files that need them import if_stage_pkg.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif

package if_stage_pkg;

  localparam int WORD_W  = `WORD_WIDTH;
  localparam int RADDR_W = `RADDR_WIDTH;

  localparam logic [WORD_W-1:0] NOP_WORD = '0;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } if_state_t;

  // Sequential PC increment; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(4);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. load captures a new instruction and marks it
// valid, bubble clears only the valid flag, otherwise everything holds.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc4_in,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc4,
  output logic              valid
);

  // Pipeline register with load taking precedence over bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-word hold buffer for words
// that arrive while the pipeline is stalled, and the IF/ID register.
// Optional feature macro: IF_PERF_CNT_EN adds the stall_cnt_87 counter.
//
//  state    | meaning
//  ST_FETCH | fetch request outstanding at PC
//  ST_HOLD  | fetched word parked in buffer while stalled, no request
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [`WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk_87,
  input  logic                    rst_87,
  input  logic                    stall_87,
  input  logic                    br_taken_87,
  input  logic [`WORD_WIDTH-1:0]  br_target_87,
  output logic                    imem_req_87,
  output logic [`WORD_WIDTH-1:0]  imem_addr_87,
  input  logic                    imem_ack_87,
  input  logic [`WORD_WIDTH-1:0]  imem_data_87,
  output logic [`WORD_WIDTH-1:0]  instr_id_87,
  output logic [`WORD_WIDTH-1:0]  pc4_id_87,
  output logic                    valid_id_87,
  output logic [`RADDR_WIDTH-1:0] r1_id_in_87,
  output logic [`RADDR_WIDTH-1:0] r2_id_in_87
`ifdef IF_PERF_CNT_EN
  ,
  output logic [`WORD_WIDTH-1:0]  stall_cnt_87
`endif
);

  if_state_t         state, state_nxt;
  logic              req_en;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_inc;
  logic [WORD_W-1:0] buf_instr;
  logic [WORD_W-1:0] buf_pc4;

  logic              id_load;
  logic              id_bubble;
  logic              id_from_buf;
  logic              pc_adv;
  logic              buf_load;
  logic [WORD_W-1:0] id_instr_in;
  logic [WORD_W-1:0] id_pc4_in;

  assign pc_inc       = pc_plus4(pc);
  assign imem_addr_87 = pc;

  // State register.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic; a redirect always returns to FETCH.
  always_comb begin
    state_nxt = state;
    if (br_taken_87) begin
      state_nxt = ST_FETCH;
    end else if (req_en) begin
      case (state)
        ST_FETCH: if (imem_ack_87 && stall_87) state_nxt = ST_HOLD;
        ST_HOLD:  if (!stall_87)               state_nxt = ST_FETCH;
        default:                               state_nxt = ST_FETCH;
      endcase
    end
  end

  // Output and datapath control decode; redirect outranks stall and ack.
  always_comb begin
    imem_req_87 = req_en && (state == ST_FETCH);
    id_load     = 1'b0;
    id_bubble   = 1'b0;
    id_from_buf = 1'b0;
    pc_adv      = 1'b0;
    buf_load    = 1'b0;
    if (br_taken_87) begin
      id_bubble = 1'b1;
    end else if (req_en) begin
      case (state)
        ST_FETCH: begin
          if (imem_ack_87) begin
            pc_adv = 1'b1;
            if (stall_87) buf_load = 1'b1;
            else          id_load  = 1'b1;
          end else if (!stall_87) begin
            id_bubble = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall_87) begin
            id_load     = 1'b1;
            id_from_buf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Requests start on the first edge after reset is released.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) req_en <= 1'b0;
    else        req_en <= 1'b1;
  end

  // Program counter; redirect targets are forced word aligned.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87)           pc <= RESET_PC;
    else if (br_taken_87) pc <= br_target_87 & ~WORD_W'(3);
    else if (pc_adv)      pc <= pc_inc;
  end

  // Hold buffer for a word acked during a stall; dropped on redirect.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      buf_instr <= NOP_WORD;
      buf_pc4   <= '0;
    end else if (br_taken_87) begin
      buf_instr <= NOP_WORD;
      buf_pc4   <= '0;
    end else if (buf_load) begin
      buf_instr <= imem_data_87;
      buf_pc4   <= pc_inc;
    end
  end

  assign id_instr_in = id_from_buf ? buf_instr : imem_data_87;
  assign id_pc4_in   = id_from_buf ? buf_pc4   : pc_inc;

  if_id_reg u_if_id_reg (
    .clk      (clk_87),
    .rst      (rst_87),
    .load     (id_load),
    .bubble   (id_bubble),
    .instr_in (id_instr_in),
    .pc4_in   (id_pc4_in),
    .instr    (instr_id_87),
    .pc4      (pc4_id_87),
    .valid    (valid_id_87)
  );

  assign r1_id_in_87 = instr_id_87[25:21];
  assign r2_id_in_87 = instr_id_87[20:16];

`ifdef IF_PERF_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87)
      stall_cnt_87 <= '0;
    else if (stall_87 && (stall_cnt_87 != {WORD_W{1'b1}}))
      stall_cnt_87 <= stall_cnt_87 + WORD_W'(1);
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage (RESET_PC = 0x100).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;
  logic [4:0]  r1;
  logic [4:0]  r2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] scnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk_87       (clk),
    .rst_87       (rst),
    .stall_87     (stall),
    .br_taken_87  (br),
    .br_target_87 (tgt),
    .imem_req_87  (req),
    .imem_addr_87 (addr),
    .imem_ack_87  (ack),
    .imem_data_87 (data),
    .instr_id_87  (instr),
    .pc4_id_87    (pc4),
    .valid_id_87  (valid),
    .r1_id_in_87  (r1),
    .r2_id_in_87  (r2)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt_87 (scnt)
`endif
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    logic [31:0] ei;
    ei = e_instr;
    n_vec++;
    chk("imem_req", idx, {31'd0, req}, {31'd0, e_req});
    chk("imem_addr", idx, addr, e_addr);
    chk("instr_id", idx, instr, e_instr);
    chk("pc4_id", idx, pc4, e_pc4);
    chk("valid_id", idx, {31'd0, valid}, {31'd0, e_valid});
    chk("r1_id", idx, {27'd0, r1}, {27'd0, ei[25:21]});
    chk("r2_id", idx, {27'd0, r2}, {27'd0, ei[20:16]});
  endtask

  localparam logic [31:0] I0 = 32'h2000_0001;
  localparam logic [31:0] I1 = 32'h2021_0002;
  localparam logic [31:0] I2 = 32'h2042_0003;
  localparam logic [31:0] IL = 32'h8C22_0004;
  localparam logic [31:0] I3 = 32'h0000_0020;
  localparam logic [31:0] I5 = 32'h0043_0820;

  initial begin
    //          stall br  tgt           ack   data           req   addr          instr  pc4           valid
    vt[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0100, 32'h0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, I0,           1'b1, 32'h0000_0100, 32'h0, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, I1,           1'b1, 32'h0000_0104, I0,    32'h0000_0104, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, I2,           1'b1, 32'h0000_0108, I1,    32'h0000_0108, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, IL,           1'b1, 32'h0000_010C, I2,    32'h0000_010C, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0110, I2,    32'h0000_010C, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0110, I2,    32'h0000_010C, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0110, I2,    32'h0000_010C, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0110, IL,    32'h0000_0110, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0110, IL,    32'h0000_0110, 1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h0,        1'b1, I3,           1'b1, 32'h0000_0110, IL,    32'h0000_0110, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0114, I3,    32'h0000_0114, 1'b1};
    vt[12] = '{1'b1, 1'b1, 32'h0000_0203, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0114, I3,  32'h0000_0114, 1'b1};
    vt[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1111_1111, 1'b1, 32'h0000_0200, I3,   32'h0000_0114, 1'b0};
    vt[14] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 32'h0000_0204, I3,    32'h0000_0114, 1'b0};
    vt[15] = '{1'b0, 1'b0, 32'h0,        1'b1, I5,           1'b1, 32'hFFFF_FFFC, I3,    32'h0000_0114, 1'b0};
    vt[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, I5,    32'h0000_0000, 1'b1};
    vt[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, I5,    32'h0000_0000, 1'b0};

    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; ack = 1'b0; data = '0;
    #1;
    chk_outputs(-1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge clk);
      rst   = 1'b0;
      stall = vt[i].stall;
      br    = vt[i].br;
      tgt   = vt[i].tgt;
      ack   = vt[i].ack;
      data  = vt[i].data;
      #1;
      chk_outputs(i, vt[i].req, vt[i].addr, vt[i].instr, vt[i].pc4, vt[i].valid);
    end

    // Reset asserted while a request is outstanding abandons it at once.
    @(negedge clk);
    stall = 1'b0; br = 1'b0; ack = 1'b0;
    #2 rst = 1'b1;
    #1 chk_outputs(100, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_outputs(101, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1 chk_outputs(102, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 1'b0);

`ifdef IF_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    #1;
    n_vec++;
    chk("stall_cnt", 200, scnt, 32'd5);
    rst = 1'b1;
    #1;
    n_vec++;
    chk("stall_cnt_rst", 201, scnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
